// File: rtl/pipe_share_pkg.sv
// Shared constants and types for the two-requester shared arithmetic pipeline.
package pipe_share_pkg;

    localparam int N_DEF     = 10;
    localparam int TAG_W_DEF = 1;
    localparam int STAGES    = 3;

    localparam logic [TAG_W_DEF-1:0] TAG_REQ0 = 1'b0;
    localparam logic [TAG_W_DEF-1:0] TAG_REQ1 = 1'b1;

    // Round-robin pointer: names the requester holding priority.
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_sel_e;

endpackage

// File: rtl/pipe_share_dp.sv
// Three-stage datapath computing f = ((a+b)+(c-d))*d mod 2^N, with valid/tag shift.
module pipe_share_dp
    import pipe_share_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [N-1:0]     c,
    input  logic [N-1:0]     d,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [N-1:0]     out_f,
    output logic             busy
);

    logic [STAGES-1:0] v_q, v_d;
    logic [TAG_W-1:0]  tag1_q, tag2_q, tag3_q;
    logic [N-1:0]      x1_q, x2_q, d1_q;
    logic [N-1:0]      x3_q, d2_q;
    logic [N-1:0]      f_q;
    logic [N-1:0]      x1_d, x2_d, x3_d, f_d;

    // All arithmetic lands in N-bit targets, so carries and borrows wrap mod 2^N.
    assign x1_d = a + b;
    assign x2_d = c - d;
    assign x3_d = x1_q + x2_q;
    assign f_d  = x3_q * d2_q;

    // Flush wins over a stall: in-flight ops are dropped even when en is low.
    always_comb begin
        v_d = v_q;
        if (flush) begin
            v_d = '0;
        end else if (en) begin
            v_d = {v_q[STAGES-2:0], in_valid};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // the previous stage's pre-edge value; blocking here would collapse the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    // NOTE: data registers are reset too, so out_f/out_tag read as zero out of reset
    // instead of whatever the flops powered up with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_q   <= '0;
            x2_q   <= '0;
            d1_q   <= '0;
            tag1_q <= '0;
            x3_q   <= '0;
            d2_q   <= '0;
            tag2_q <= '0;
            f_q    <= '0;
            tag3_q <= '0;
        end else if (en) begin
            x1_q   <= x1_d;
            x2_q   <= x2_d;
            d1_q   <= d;
            tag1_q <= in_tag;
            x3_q   <= x3_d;
            d2_q   <= d1_q;
            tag2_q <= tag1_q;
            f_q    <= f_d;
            tag3_q <= tag2_q;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_tag   = tag3_q;
    assign out_f     = f_q;
    assign busy      = |v_q;

endmodule

// File: rtl/pipe_share_ctrl.sv
// Round-robin sharing of one arithmetic pipeline between two requesters, with global stall.
module pipe_share_ctrl
    import pipe_share_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [N-1:0]     req0_a,
    input  logic [N-1:0]     req0_b,
    input  logic [N-1:0]     req0_c,
    input  logic [N-1:0]     req0_d,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [N-1:0]     req1_a,
    input  logic [N-1:0]     req1_b,
    input  logic [N-1:0]     req1_c,
    input  logic [N-1:0]     req1_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [N-1:0]     out_f,
    output logic             busy
);

    req_sel_e         rr_q, rr_d;
    logic             stall, advance;
    logic             grant0, grant1, issue;
    logic [TAG_W-1:0] sel_tag;
    logic [N-1:0]     sel_a, sel_b, sel_c, sel_d;

    assign stall   = out_valid & ~out_ready;
    assign advance = ~stall;

    // rst gates the grants so both readies read low while reset is held.
    assign grant0 = ~rst & req0_valid & advance & ~flush & ((rr_q == REQ0) | ~req1_valid);
    assign grant1 = ~rst & req1_valid & advance & ~flush & ((rr_q == REQ1) | ~req0_valid);
    assign issue  = grant0 | grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        rr_d = rr_q;
        if (grant0) begin
            rr_d = REQ1;
        end else if (grant1) begin
            rr_d = REQ0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= REQ0;
        end else begin
            rr_q <= rr_d;
        end
    end

    always_comb begin
        sel_tag = TAG_W'(TAG_REQ0);
        sel_a   = req0_a;
        sel_b   = req0_b;
        sel_c   = req0_c;
        sel_d   = req0_d;
        if (grant1) begin
            sel_tag = TAG_W'(TAG_REQ1);
            sel_a   = req1_a;
            sel_b   = req1_b;
            sel_c   = req1_c;
            sel_d   = req1_d;
        end
    end

    pipe_share_dp #(
        .N     (N),
        .TAG_W (TAG_W)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .en        (advance),
        .flush     (flush),
        .in_valid  (issue),
        .in_tag    (sel_tag),
        .a         (sel_a),
        .b         (sel_b),
        .c         (sel_c),
        .d         (sel_d),
        .out_valid (out_valid),
        .out_tag   (out_tag),
        .out_f     (out_f),
        .busy      (busy)
    );

endmodule

// File: tb/tb_pipe_share_ctrl.sv
// Scoreboard bench for pipe_share_ctrl: arbitration, latency, wrap, stall, flush, reset.
module tb_pipe_share_ctrl;
    import pipe_share_pkg::*;

    localparam int N     = N_DEF;
    localparam int TAG_W = TAG_W_DEF;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             req0_valid, req0_ready;
    logic [N-1:0]     req0_a, req0_b, req0_c, req0_d;
    logic             req1_valid, req1_ready;
    logic [N-1:0]     req1_a, req1_b, req1_c, req1_d;
    logic             out_valid, out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [N-1:0]     out_f;
    logic             busy;

    typedef struct {
        logic [N-1:0]     f;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pops   = 0;

    pipe_share_ctrl #(.N(N), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_c     (req0_c),
        .req0_d     (req0_d),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_c     (req1_c),
        .req1_d     (req1_d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tag    (out_tag),
        .out_f      (out_f),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model_f(input logic [N-1:0] a, b, c, d);
        logic [N-1:0] s, t, u, p;
        s = a + b;
        t = c - d;
        u = s + t;
        p = u * d;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [N-1:0] a, b, c, d);
        req0_valid = v; req0_a = a; req0_b = b; req0_c = c; req0_d = d;
    endtask

    task automatic set_req1(input logic v, input logic [N-1:0] a, b, c, d);
        req1_valid = v; req1_a = a; req1_b = b; req1_c = c; req1_d = d;
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) step();
        check(tag, sb_q.size(), 0);
    endtask

    // Monitor: handshakes are sampled mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_out", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_f", out_f, e.f);
                    check("sb_tag", out_tag, e.tag);
                    n_pops++;
                end
            end
            if (flush) sb_q.delete();
            if (req0_valid && req0_ready)
                sb_q.push_back('{f: model_f(req0_a, req0_b, req0_c, req0_d), tag: TAG_W'(TAG_REQ0)});
            if (req1_valid && req1_ready)
                sb_q.push_back('{f: model_f(req1_a, req1_b, req1_c, req1_d), tag: TAG_W'(TAG_REQ1)});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        set_req0(1'b1, 0, 0, 0, 0);
        set_req1(1'b0, 0, 0, 0, 0);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_f", out_f, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_req0_ready", req0_ready, 0);
        req0_valid = 1'b0;
        step(); step();
        rst = 1'b0;

        // Single op from req0: result appears after the third edge past issue.
        step();
        set_req0(1'b1, 5, 6, 7, 8);
        #1;
        check("t1_req0_ready", req0_ready, 1);
        check("t1_req1_ready", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        #1;
        check("t1_busy_s1", busy, 1);
        check("t1_ov_s1", out_valid, 0);
        step(); check("t1_ov_s2", out_valid, 0);
        step();
        check("t1_ov_s3", out_valid, 1);
        check("t1_f", out_f, 80);
        check("t1_tag", out_tag, 0);
        check("t1_busy_s3", busy, 1);
        step();
        check("t1_ov_after", out_valid, 0);
        check("t1_busy_after", busy, 0);

        // Wrap-around through req1 alone (also leaves priority with req0).
        set_req1(1'b1, 1000, 1000, 0, 2);
        #1;
        check("wr_req1_ready", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        #1;
        check("wr_x1", dut.u_dp.x1_q, 976);
        check("wr_x2", dut.u_dp.x2_q, 1022);
        step();
        check("wr_x3", dut.u_dp.x3_q, 974);
        step();
        check("wr_ov", out_valid, 1);
        check("wr_f", out_f, 924);
        check("wr_tag", out_tag, 1);
        step();

        // Both requesters stream: grants alternate from req0, one result per cycle.
        for (int i = 0; i < 8; i++) begin
            set_req0(1'b1, 9, 10, 11, 12);
            set_req1(1'b1, 10, 6, 7, 8);
            #1;
            check("st_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
            check("st_req1_ready", req1_ready, (i % 2 == 1) ? 1 : 0);
            if (i >= 3) begin
                check("st_ov", out_valid, 1);
                check("st_f", out_f, ((i - 3) % 2 == 0) ? 216 : 120);
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain("st_drain");

        // Backpressure: three ops in flight, consumer stalls four cycles.
        base = n_pops;
        set_req0(1'b1, 1, 2, 3, 4); #1; check("bp_fill0", req0_ready, 1); step();
        set_req0(1'b1, 5, 5, 5, 5); #1; check("bp_fill1", req0_ready, 1); step();
        set_req0(1'b1, 7, 1, 2, 3); #1; check("bp_fill2", req0_ready, 1); step();
        set_req0(1'b1, 2, 2, 2, 2);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("bp_ov", out_valid, 1);
            check("bp_f_hold", out_f, 8);
            check("bp_tag_hold", out_tag, 0);
            check("bp_ready0", req0_ready, 0);
            check("bp_ready1", req1_ready, 0);
            check("bp_s1_hold", dut.u_dp.x1_q, 8);
            check("bp_s2_hold", dut.u_dp.x3_q, 10);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        wait_drain("bp_drain");
        check("bp_pop_count", n_pops - base, 4);

        // Flush with all three stages full, during a stall.
        set_req0(1'b1, 3, 3, 3, 3); step();
        set_req0(1'b1, 4, 4, 4, 4); step();
        set_req0(1'b1, 6, 6, 6, 6); step();
        set_req0(1'b1, 8, 8, 8, 8);
        flush = 1'b1; out_ready = 1'b0;
        #1;
        check("fl_ready0", req0_ready, 0);
        check("fl_busy_before", busy, 1);
        step();
        flush = 1'b0; out_ready = 1'b1; req0_valid = 1'b0;
        #1;
        check("fl_busy", busy, 0);
        check("fl_ov", out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("fl_no_out", out_valid, 0);
        end
        check("fl_sb_empty", sb_q.size(), 0);

        // Asynchronous reset mid-stream, taken while req1 holds priority.
        for (int i = 0; i < 4; i++) begin
            set_req0(1'b1, 9, 10, 11, 12);
            set_req1(1'b1, 10, 6, 7, 8);
            step();
        end
        #1;
        check("ar_ov_before", out_valid, 1);
        check("ar_rr_before", req1_ready, 1);
        #1;
        rst = 1'b1;
        #1;
        check("ar_ov", out_valid, 0);
        check("ar_busy", busy, 0);
        check("ar_f", out_f, 0);
        check("ar_tag", out_tag, 0);
        check("ar_ready0", req0_ready, 0);
        check("ar_ready1", req1_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("ar_rr0_ready0", req0_ready, 1);
        check("ar_rr0_ready1", req1_ready, 0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain("ar_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
